// File: rtl/seq_mul_32.sv
// Iterative 32x32 unsigned shift-and-add multiplier that borrows an external
// 32-bit combinational adder; one partial product per cycle, 64-bit result.
module seq_mul_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   h_q;
    logic [WIDTH-1:0]   q_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               load;
    logic               step;
    logic               finish;
    logic [WIDTH-1:0]   h_next;
    logic [WIDTH-1:0]   q_next;

    // Next-state and control decode; handshake outputs follow the next state
    // so they can be registered alongside it.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Adder operands are only live during RUN so the shared adder sees zeros otherwise.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state_q == RUN) begin
            add_a = h_q;
            add_b = q_q[0] ? m_q : '0;
        end
    end

    // Carry-out becomes the new MSB of H; the sum LSB shifts into the top of Q.
    always_comb begin
        h_next = {add_cout, add_sum[WIDTH-1:1]};
        q_next = {add_sum[0], q_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            m_q       <= '0;
            h_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product   <= '0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            if (load) begin
                m_q   <= a;
                q_q   <= b;
                h_q   <= '0;
                cnt_q <= '0;
            end
            if (step) begin
                h_q   <= h_next;
                q_q   <= q_next;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                product <= PROD_W'({h_next, q_next});
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_32.sv
// Self-checking bench for seq_mul_32: directed vector table, hand-written
// back-pressure / reset sequences, and random pairs against a plain 64-bit multiply.
module tb_seq_mul_32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [32:0] add_full;

    int n_checks;
    int n_fail;

    seq_mul_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Stand-in for the team's 32-bit combinational adder.
    assign add_full = {1'b0, add_a} + {1'b0, add_b};
    assign add_sum  = add_full[31:0];
    assign add_cout = add_full[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check handshake, latency, first adder operands,
    // product stability under stall, and the return to IDLE.
    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input int stall,
                          input logic [63:0] exp, input string name);
        int lat;
        check({name, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a         = ai;
        b         = bi;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        check({name, "_in_ready_drop"}, 64'(in_ready), 64'd0);
        check({name, "_add_a_first"}, 64'(add_a), 64'd0);
        check({name, "_add_b_first"}, 64'(add_b), bi[0] ? 64'(ai) : 64'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_product"}, product, exp);
        for (int i = 0; i < stall; i++) begin
            step();
            check({name, "_stall_valid"}, 64'(out_valid), 64'd1);
            check({name, "_stall_product"}, product, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready_back"}, 64'(in_ready), 64'd1);
        check({name, "_product_kept"}, product, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{32'd3,          32'd5,          0,  64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  0,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h1234_5678,  32'd0,          0,  64'h0};
        vecs[3] = '{32'h1234_5678,  32'd1,          0,  64'h0000_0000_1234_5678};
        vecs[4] = '{32'd0,          32'hFFFF_FFFF,  2,  64'h0};
        vecs[5] = '{32'hFFFF_FFFF,  32'd2,          1,  64'h0000_0001_FFFF_FFFE};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  3,  64'h0000_0001_0000_0000};
        vecs[7] = '{32'h8000_0000,  32'h8000_0000,  10, 64'h4000_0000_0000_0000};

        #22;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product",   product,        64'd0);
        check("rst_add_a",     64'(add_a),     64'd0);
        check("rst_add_b",     64'(add_b),     64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-pressure with in_valid pulses in RUN and in DONE (with out_ready).
        a        = 32'h8000_0000;
        b        = 32'h8000_0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat == 5) begin
                a        = 32'd11;
                b        = 32'd13;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        check("bp_latency", 64'(lat), 64'd32);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid_held", 64'(out_valid), 64'd1);
            check("bp_product_held", product, 64'h4000_0000_0000_0000);
        end
        a         = 32'd11;
        b         = 32'd13;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_exit_valid", 64'(out_valid), 64'd0);
        check("bp_exit_in_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_done_ivalid_ignored", 64'(in_ready), 64'd1);
        check("bp_product_retained", product, 64'h4000_0000_0000_0000);

        // Asynchronous reset in the middle of an operation.
        a        = 32'd7;
        b        = 32'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_product",   product,        64'd0);
        check("midrst_add_b",     64'(add_b),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(32'd7, 32'd9, 0, 64'd63, "post_rst");

        // Random back-to-back against a plain 64-bit multiply.
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ((i % 7) == 0) ra[31:16] = 16'hFFFF;
            run_op(ra, rb, int'($urandom_range(0, 3)), 64'(ra) * 64'(rb), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul_32.md
# seq_mul_32

Iterative 32x32 unsigned shift-and-add multiplier that sits directly upstream and downstream of the team's 32-bit combinational adder. Each iteration drives the adder operands from internal state and consumes the adder's sum and carry-out on the same cycle. The 64-bit product is returned after a fixed 32 iterations behind a valid/ready handshake. The block gives the ToyALU a multiply operation without adding a second wide adder.

## Interface
- No parameters. Width is fixed at 32 to match the adder.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept operands. High only in IDLE.
- a  in  32  multiplicand, unsigned.
- b  in  32  multiplier, unsigned.
- out_valid  out  1  product is valid. High only in DONE.
- out_ready  in  1  consumer accepts the product.
- product  out  64  a*b, registered, held stable while out_valid=1.
- add_a  out  32  adder operand A.
- add_b  out  32  adder operand B.
- add_sum  in  32  adder sum, combinationally add_a+add_b.
- add_cout  in  1  adder carry-out (bit 32 of add_a+add_b).

## Operation
- Internal registers:
  - M[31:0]: latched multiplicand.
  - H[31:0]: accumulator high half.
  - Q[31:0]: multiplier, shifting into the low half.
  - cnt[4:0]: iteration count.
  - state: one of IDLE, RUN, DONE.
- Reset (async, rst_n=0):
  - state=IDLE, M=H=Q=0, cnt=0, product=0.
  - out_valid=0, in_ready=1.
  - Reset asserted mid-RUN or in DONE abandons the operation; no output is produced.
- IDLE:
  - in_ready=1.
  - On in_valid=1: M<=a, Q<=b, H<=0, cnt<=0, state<=RUN.
- RUN (in_ready=0, out_valid=0):
  - Drive add_a=H and add_b = Q[0] ? M : 0.
  - Each edge: H<={add_cout, add_sum[31:1]}, Q<={add_sum[0], Q[31:1]}, cnt<=cnt+1.
  - When cnt==31, on that edge also product<={next H, next Q} and state<=DONE.
  - The shift into H uses add_cout, so no carry is lost.
  - in_valid during RUN is ignored; operands are not re-sampled.
- DONE (in_ready=0, out_valid=1):
  - product held.
  - On out_ready=1: state<=IDLE.
  - in_valid in DONE is not accepted, even if out_ready=1 on the same cycle. The next operand can be accepted on the following cycle at the earliest.
- Adder operands outside RUN: add_a=0, add_b=0.
- Arithmetic is unsigned.
  - Result: product = a*b exactly, full 64 bits, never truncated.
  - b=0 or a=0 still takes the full 32 iterations; there is no early-out.
- product retains the last result after leaving DONE until the next completion or reset.

## Timing
- Acceptance edge E0: IDLE with in_valid=1.
- Iterations happen at edges E1..E32.
- out_valid rises after E32: fixed latency of 32 cycles from acceptance to out_valid.
- With out_ready tied high:
  - DONE lasts exactly 1 cycle.
  - in_ready returns high after E33.
  - Throughput is one multiply per 34 cycles.
- Back-pressure: out_valid and product stay stable for any number of cycles with out_ready=0.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- The adder path is combinational within one cycle: add_a/add_b → add_sum/add_cout → H/Q registers.

## Test plan
- Basic: a=3, b=5, out_ready=1.
  - in_ready drops after E0.
  - out_valid=1 exactly 32 cycles later with product=0x0000_0000_0000_000F.
  - in_ready=1 after E33.
- Max operands: a=b=0xFFFF_FFFF.
  - product=0xFFFF_FFFE_0000_0001.
  - Checks add_cout capture on every iteration.
- Zero and identity: a=0x1234_5678, b=0 gives product=0, still after 32 cycles. a=0x1234_5678, b=1 gives product=0x0000_0000_1234_5678.
- Back-pressure: a=0x8000_0000, b=0x8000_0000, out_ready=0 for 10 cycles.
  - out_valid held high with product=0x4000_0000_0000_0000 stable.
  - in_valid pulsed during RUN and DONE is ignored.
  - Raising out_ready returns to IDLE next edge.
- Reset mid-operation: start a=7, b=9, pull rst_n low asynchronously at iteration 10.
  - All outputs are immediately at reset values: out_valid=0, in_ready=1, product=0.
  - Then a=7, b=9 after release gives product=63.
- Randomized back-to-back: 1000 random pairs with random out_ready stalls, checked against a 64-bit reference multiply. add_sum is supplied by the team's 32-bit adder instance.
